alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
- Execute-side counterpart of the decode-stage ALU-op encoder: consumes the 3-bit aluop class code together with funct3/funct7 and the two operands, decodes the concrete ALU operation, and produces the result.
- Sits between the ID/EX register and writeback/branch resolution.
- Add, logic and compare operations complete in one cycle.
- Shifts run iteratively, one bit per cycle, to save area.
- Valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, operand/result width.
- SHW, $clog2(XLEN), shift-amount width.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous abort of any in-flight operation.
- in_valid_i  input  1  operation offered.
- in_ready_o  output  1  unit can accept.
- aluop_i  input  3  class: 000 R, 001 I, 010 branch, 011 jal/jalr, 100 load, 101 store, 110 lui, 111 invalid.
- funct3_i  input  3  instruction funct3.
- funct7_i  input  7  instruction funct7 (only bit 5 used).
- op_a_i  input  XLEN  rs1 or PC.
- op_b_i  input  XLEN  rs2 or immediate.
- out_valid_o  output  1  result available.
- out_ready_i  input  1  consumer accepts result.
- result_o  output  XLEN  ALU result / link address / address.
- branch_taken_o  output  1  branch condition true (aluop 010 only).
- illegal_o  output  1  unsupported aluop/funct combination.

Behaviour:
- Reset (rst_ni low, async): state IDLE, in_ready_o=1, out_valid_o=0, result_o=0, branch_taken_o=0, illegal_o=0, shift counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready_o=1. Accept when in_valid_i && in_ready_o. Operands and decoded op are latched on acceptance.
  - Non-shift op: result computed and registered; next state DONE (out_valid_o one cycle after accept).
  - Shift op: load shifter with op_a_i and counter with op_b_i[SHW-1:0].
    - Count 0: go to DONE with result=op_a.
    - Otherwise go to SHIFT.
- SHIFT: in_ready_o=0. Each cycle shift one bit (SLL left, SRL zero-fill, SRA sign-fill) and decrement counter. When counter reaches 1→0, go to DONE. Shift by n yields out_valid_o n+1 cycles after accept.
- DONE: out_valid_o=1. result_o, branch_taken_o and illegal_o are held stable until out_ready_i; on out_ready_i, go to IDLE and deassert out_valid_o the next cycle. No new acceptance in DONE (in_ready_o=0); one operation in flight at most.
- Decode, aluop 000 (R):
  - funct3 000 → ADD, or SUB if funct7[5].
  - 001 SLL; 010 SLT (signed); 011 SLTU.
  - 100 XOR; 101 SRL, or SRA if funct7[5]; 110 OR; 111 AND.
  - funct7 values other than 0000000/0100000 → illegal_o=1, result 0.
- aluop 001 (I): as R, except funct3 000 is always ADD. funct7[5] is honoured only for funct3 101 (SRAI). funct3 001 with funct7≠0 is illegal.
- aluop 010 (branch):
  - funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - branch_taken_o=condition; result_o = zero-extended condition.
  - funct3 010/011 → illegal_o=1, branch_taken_o=0.
- aluop 011: result = op_a + 4 (link address), wrap modulo 2^XLEN.
- aluop 100/101: result = op_a + op_b (effective address), wrap modulo 2^XLEN.
- aluop 110: result = op_b (LUI immediate passthrough).
- aluop 111: illegal_o=1, result 0, still completes via DONE in 1 cycle.
- branch_taken_o=0 for every non-branch class.
- Arithmetic: all add/sub wrap modulo 2^XLEN. SLT/SLTU produce 0 or 1 in bit 0. Shift amount uses only the low SHW bits of op_b.
- flush_i: in any state, next state IDLE, out_valid_o=0, result discarded.
  - flush_i has priority over in_valid_i and out_ready_i in the same cycle.
  - An in_valid_i coinciding with flush_i is not accepted.
- Reset mid-operation (SHIFT or DONE): immediate return to reset values; no output emitted.
- out_ready_i asserted while out_valid_o=0: ignored.

Test Plan:
- Reset then aluop=000, funct3=000, funct7=0100000, a=5, b=7 → one cycle later out_valid_o=1, result=0xFFFFFFFE, illegal_o=0; held while out_ready_i=0 for 3 cycles.
- aluop=001, funct3=101, funct7=0100000, a=0x80000000, b=4 → out_valid_o exactly 5 cycles after accept, result=0xF8000000; in_ready_o=0 throughout.
- aluop=010, funct3=100, a=0xFFFFFFFF, b=1 → branch_taken_o=1; same with funct3=110 → branch_taken_o=0; funct3=010 → illegal_o=1.
- aluop=011, a=0xFFFFFFFC → result=0x00000000; aluop=110, b=0x12345000 → result=0x12345000; aluop=111 → illegal_o=1, result=0.
- SLL by 31 with flush_i asserted on cycle 10 → out_valid_o never rises; in_ready_o=1 on the cycle after flush; next op ADD 1+1 → result=2.
- rst_ni low during SHIFT (SRL by 20) → all outputs return to reset values asynchronously; after release, shift by 0 of a=0xA5 → result=0xA5 one cycle after accept.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage ALU: single-cycle add/logic/compare, bit-serial shifts
module alu_exec_ctrl #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      aluop_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            branch_taken_o,
    output logic            illegal_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shmode_t;

    state_t          state_q;
    shmode_t         mode_q, dec_mode;
    logic [XLEN-1:0] sh_q, sh_d;
    logic [SHW-1:0]  cnt_q;
    logic            in_ready_q, out_valid_q, taken_q, illegal_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] sum, diff, dec_res;
    logic            lt, ltu, eq, is_i, f7_ok;
    logic            dec_shift, dec_taken, dec_illegal;

    assign sum   = op_a_i + op_b_i;
    assign diff  = op_a_i - op_b_i;
    assign lt    = $signed(op_a_i) < $signed(op_b_i);
    assign ltu   = op_a_i < op_b_i;
    assign eq    = op_a_i == op_b_i;
    assign is_i  = aluop_i[0];
    assign f7_ok = (funct7_i == 7'b0000000) || (funct7_i == 7'b0100000);

    // For I-type, funct7 is immediate payload except on the shift encodings.
    always_comb begin
        dec_res     = '0;
        dec_shift   = 1'b0;
        dec_mode    = SH_LL;
        dec_taken   = 1'b0;
        dec_illegal = 1'b0;
        case (aluop_i)
            3'b000, 3'b001: begin
                if ((!is_i && !f7_ok) ||
                    (is_i && funct3_i == 3'b001 && funct7_i != 7'b0000000) ||
                    (is_i && funct3_i == 3'b101 && !f7_ok)) begin
                    dec_illegal = 1'b1;
                end else begin
                    case (funct3_i)
                        3'b000: dec_res = (!is_i && funct7_i[5]) ? diff : sum;
                        3'b001: dec_shift = 1'b1;
                        3'b010: dec_res = {{(XLEN-1){1'b0}}, lt};
                        3'b011: dec_res = {{(XLEN-1){1'b0}}, ltu};
                        3'b100: dec_res = op_a_i ^ op_b_i;
                        3'b101: begin
                            dec_shift = 1'b1;
                            dec_mode  = funct7_i[5] ? SH_RA : SH_RL;
                        end
                        3'b110: dec_res = op_a_i | op_b_i;
                        default: dec_res = op_a_i & op_b_i;
                    endcase
                end
            end
            3'b010: begin
                case (funct3_i)
                    3'b000: dec_taken = eq;
                    3'b001: dec_taken = !eq;
                    3'b100: dec_taken = lt;
                    3'b101: dec_taken = !lt;
                    3'b110: dec_taken = ltu;
                    3'b111: dec_taken = !ltu;
                    default: dec_illegal = 1'b1;
                endcase
                dec_res = {{(XLEN-1){1'b0}}, dec_taken};
            end
            3'b011:         dec_res = op_a_i + XLEN'(4);
            3'b100, 3'b101: dec_res = sum;
            3'b110:         dec_res = op_b_i;
            default:        dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (mode_q)
            SH_RL:   sh_d = {1'b0, sh_q[XLEN-1:1]};
            SH_RA:   sh_d = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
            default: sh_d = {sh_q[XLEN-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
            sh_q        <= '0;
            mode_q      <= SH_LL;
        end else if (flush_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i && in_ready_q) begin
                    in_ready_q <= 1'b0;
                    taken_q    <= dec_taken;
                    illegal_q  <= dec_illegal;
                    if (dec_shift) begin
                        sh_q   <= op_a_i;
                        cnt_q  <= op_b_i[SHW-1:0];
                        mode_q <= dec_mode;
                        if (op_b_i[SHW-1:0] == '0) begin
                            result_q    <= op_a_i;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end else begin
                        result_q    <= dec_res;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        result_q    <= sh_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: if (out_ready_i) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o     = in_ready_q;
    assign out_valid_o    = out_valid_q;
    assign result_o       = result_q;
    assign branch_taken_o = taken_q;
    assign illegal_o      = illegal_q;
endmodule
